updown_counter_param: RTL and testbench

- Parametrised successor to the team's fixed 4-bit up/down counter for the ForgeFPGA target.
- Generalised in width, modulus and count rate.
- Adds a clock-enable prescaler, synchronous parallel load, wrap/saturate mode and a terminal-count pulse.
- Sits between the board oscillator/IO tie-offs and LED/GPIO outputs; it is also the base counter for later timer blocks.

---
 rtl/updown_counter_param.sv | 110 +++++++++++
 tb/tb_updown_counter_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clock-enable prescaler, synchronous load,
// wrap/saturate bound handling and a one-cycle terminal-count pulse.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_limit,
    output logic [WIDTH-1:0] out_oe,
    output logic             osc_en
);

    // A 1-bit prescaler is kept for PRESCALE=1 so the compare below stays legal; it never leaves 0.
    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PS_W-1:0]  PS_ZERO = {PS_W{1'b0}};
    localparam logic [PS_W-1:0]  PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic [PS_W-1:0]  ps_r;

    logic             step_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             wrap_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] load_clamp_s;
    logic [PS_W-1:0]  ps_nxt_s;

    // Next-state decode for a step: bound detection, wrap/saturate and load clamping.
    always_comb begin
        at_max_s     = (count_r == MAX_C);
        at_zero_s    = (count_r == ZERO_C);
        step_s       = enable & (ps_r == PS_LAST);
        count_nxt_s  = count_r;
        wrap_s       = 1'b0;
        if (up_down) begin
            if (!at_max_s) begin
                count_nxt_s = count_r + ONE_C;
            end else if (!sat_mode) begin
                count_nxt_s = ZERO_C;
                wrap_s      = 1'b1;
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            if (!at_zero_s) begin
                count_nxt_s = count_r - ONE_C;
            end else if (!sat_mode) begin
                count_nxt_s = MAX_C;
                wrap_s      = 1'b1;
            end else begin
                count_nxt_s = count_r;
            end
        end
        if (load_value > MAX_C) begin
            load_clamp_s = MAX_C;
        end else begin
            load_clamp_s = load_value;
        end
        if (!enable) begin
            ps_nxt_s = ps_r;
        end else if (ps_r == PS_LAST) begin
            ps_nxt_s = PS_ZERO;
        end else begin
            ps_nxt_s = ps_r + PS_ONE;
        end
    end

    // State registers: reset beats load, load beats (and discards) a coincident step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= ZERO_C;
            tc_r    <= 1'b0;
            ps_r    <= PS_ZERO;
        end else if (load) begin
            count_r <= load_clamp_s;
            tc_r    <= 1'b0;
            ps_r    <= PS_ZERO;
        end else begin
            ps_r <= ps_nxt_s;
            tc_r <= step_s & wrap_s;
            if (step_s) begin
                count_r <= count_nxt_s;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign count    = count_r;
    assign tc       = tc_r;
    assign at_limit = up_down ? at_max_s : at_zero_s;
    assign out_oe   = {WIDTH{1'b1}};
    assign osc_en   = 1'b1;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: three counter instances (16/1, 10/1, 10/4) share stimulus;
// expected responses are queued by the driver and checked by a monitor process.
module tb_updown_counter_param;

    typedef struct {
        int cnt;
        int tcv;
        int al;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       sat_mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] cnt0, cnt1, cnt2, oe0, oe1, oe2;
    logic       tc0, tc1, tc2, al0, al1, al2, osc0, osc1, osc2;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int modv[3] = '{16, 10, 10};
    int prev[3] = '{1, 1, 4};
    int m_cnt[3] = '{0, 0, 0};
    int m_ps[3] = '{0, 0, 0};
    int m_tc[3] = '{0, 0, 0};

    updown_counter_param #(.WIDTH(4), .MODULO(16), .PRESCALE(1)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
        .load(load), .load_value(load_value), .count(cnt0), .tc(tc0), .at_limit(al0),
        .out_oe(oe0), .osc_en(osc0));
    updown_counter_param #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
        .load(load), .load_value(load_value), .count(cnt1), .tc(tc1), .at_limit(al1),
        .out_oe(oe1), .osc_en(osc1));
    updown_counter_param #(.WIDTH(4), .MODULO(10), .PRESCALE(4)) u2 (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .sat_mode(sat_mode),
        .load(load), .load_value(load_value), .count(cnt2), .tc(tc2), .at_limit(al2),
        .out_oe(oe2), .osc_en(osc2));

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model of one instance for the edge about to happen.
    task automatic model(input int i, input logic rs, en, ud, sat, ld, input int lv);
        int last;
        last = modv[i] - 1;
        if (rs) begin
            m_cnt[i] = 0; m_ps[i] = 0; m_tc[i] = 0;
        end else if (ld) begin
            m_cnt[i] = (lv > last) ? last : lv;
            m_ps[i] = 0; m_tc[i] = 0;
        end else if (en && m_ps[i] == prev[i] - 1) begin
            m_ps[i] = 0; m_tc[i] = 0;
            if (ud) begin
                if (m_cnt[i] != last) m_cnt[i] = m_cnt[i] + 1;
                else if (!sat) begin m_cnt[i] = 0; m_tc[i] = 1; end
            end else begin
                if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
                else if (!sat) begin m_cnt[i] = last; m_tc[i] = 1; end
            end
        end else begin
            if (en) m_ps[i] = m_ps[i] + 1;
            m_tc[i] = 0;
        end
    endtask

    function automatic exp_t mk(input int i, input logic ud);
        exp_t e;
        e.cnt = m_cnt[i];
        e.tcv = m_tc[i];
        e.al  = ud ? int'(m_cnt[i] == modv[i] - 1) : int'(m_cnt[i] == 0);
        return e;
    endfunction

    task automatic cyc(input logic rs, en, ud, sat, ld, input logic [3:0] lv);
        @(negedge clk);
        reset = rs; enable = en; up_down = ud; sat_mode = sat; load = ld; load_value = lv;
        for (int i = 0; i < 3; i++) model(i, rs, en, ud, sat, ld, int'(lv));
        q0.push_back(mk(0, ud));
        q1.push_back(mk(1, ud));
        q2.push_back(mk(2, ud));
    endtask

    task automatic run(input int n, input logic rs, en, ud, sat, ld, input logic [3:0] lv);
        for (int k = 0; k < n; k++) cyc(rs, en, ud, sat, ld, lv);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle, compare each instance against its queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("u0_count", int'(cnt0), e.cnt); cmp("u0_tc", int'(tc0), e.tcv); cmp("u0_at_limit", int'(al0), e.al);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("u1_count", int'(cnt1), e.cnt); cmp("u1_tc", int'(tc1), e.tcv); cmp("u1_at_limit", int'(al1), e.al);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp("u2_count", int'(cnt2), e.cnt); cmp("u2_tc", int'(tc2), e.tcv); cmp("u2_at_limit", int'(al2), e.al);
            end
            cmp("oe_const", int'({oe0, oe1, oe2}), 12'hFFF);
            cmp("osc_const", int'({osc0, osc1, osc2}), 7);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #93;
        cmp("reset_u0_count", int'(cnt0), 0);
        cmp("reset_u2_count", int'(cnt2), 0);
        cmp("reset_tc", int'({tc0, tc1, tc2}), 0);
        cmp("reset_oe", int'(oe0), 15);
        cmp("reset_osc", int'(osc0), 1);

        // Up count across the full range and wrap
        run(16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("up_wrap_u0_count", int'(cnt0), 0);
        cmp("up_wrap_u0_tc", int'(tc0), 1);
        cmp("up_mod10_u1_count", int'(cnt1), 6);
        cmp("up_pre4_u2_count", int'(cnt2), 4);

        // Load 5 then count down
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        run(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("down_u0_count", int'(cnt0), 2);
        cmp("down_pre4_u2_hold", int'(cnt2), 5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("down_pre4_u2_step", int'(cnt2), 4);
        cmp("down_u0_count2", int'(cnt0), 1);

        // Down wrap from 0
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("down_wrap_u1_count", int'(cnt1), 9);
        cmp("down_wrap_u1_tc", int'(tc1), 1);
        cmp("down_wrap_u0_count", int'(cnt0), 15);

        // Saturate at top, then at bottom
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        run(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        settle();
        cmp("sat_up_u1_count", int'(cnt1), 9);
        cmp("sat_up_u1_at_limit", int'(al1), 1);
        cmp("sat_up_u1_tc", int'(tc1), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        #1;
        cmp("at_limit_follows_dir", int'(al1), 0);
        run(11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        settle();
        cmp("sat_down_u1_count", int'(cnt1), 0);
        cmp("sat_down_u1_at_limit", int'(al1), 1);
        cmp("sat_down_u0_count", int'(cnt0), 0);
        cmp("sat_down_u2_count", int'(cnt2), 6);

        // Enable gap mid-prescale keeps the phase
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        run(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("gap_u2_step", int'(cnt2), 7);
        run(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("gap_u2_hold", int'(cnt2), 7);

        // Clamped load with coincident step, then next step 4 edges later
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
        settle();
        cmp("load_clamp_u2", int'(cnt2), 9);
        cmp("load_clamp_u1", int'(cnt1), 9);
        cmp("load_noclamp_u0", int'(cnt0), 12);
        run(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("post_load_u2_hold", int'(cnt2), 9);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("post_load_u2_wrap", int'(cnt2), 0);
        cmp("post_load_u2_tc", int'(tc2), 1);

        // Asynchronous reset mid-count
        run(6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("pre_reset_u0_count", int'(cnt0), 6);
        cmp("pre_reset_u2_count", int'(cnt2), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        cmp("async_reset_counts", int'({cnt0, cnt1, cnt2}), 0);
        cmp("async_reset_tc", int'({tc0, tc1, tc2}), 0);
        cmp("async_reset_oe", int'(oe2), 15);
        cmp("async_reset_osc", int'(osc2), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        run(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("post_reset_u2_hold", int'(cnt2), 0);
        cmp("post_reset_u0_count", int'(cnt0), 3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        settle();
        cmp("post_reset_u2_first", int'(cnt2), 1);

        @(posedge clk);
        #3;
        cmp("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
